// File: rtl/voice_allocator_if.sv
`default_nettype none
// ============================================================================
// Module   : voice_allocator_if
// Brief    : Note-request handshake between score logic and voice allocator.
// Revision : 1.0
// ============================================================================
interface voice_allocator_if #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 20
);
  logic              note_valid_in;
  logic              note_ready_out;
  logic [NOTE_W-1:0] note_id_in;
  logic              note_pan_in;
  logic [DUR_W-1:0]  note_dur_in;

  modport master (
    output note_valid_in,
    output note_id_in,
    output note_pan_in,
    output note_dur_in,
    input  note_ready_out
  );

  modport slave (
    input  note_valid_in,
    input  note_id_in,
    input  note_pan_in,
    input  note_dur_in,
    output note_ready_out
  );
endinterface
`default_nettype wire

// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : voice_allocator
// Brief    : Assigns note requests to three voices (retrigger, free, steal)
//            and times each voice's duration in sample ticks.
// Revision : 1.0
// ============================================================================
module voice_allocator #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 20
) (
  input  wire logic                clk_in,
  input  wire logic                rst_in_n,
  input  wire logic                sample_tick_in,
  input  wire logic                all_off_in,
  voice_allocator_if.slave         note_if,
  output logic [2:0]               voice_active_out,
  output logic [3*NOTE_W-1:0]      voice_note_out,
  output logic [2:0]               voice_pan_out,
  output logic [2:0]               voice_start_out,
  output logic                     steal_out
);

  typedef enum logic {
    IDLE    = 1'b0,
    PLAYING = 1'b1
  } voice_state_e;

  voice_state_e      state_q [3];
  voice_state_e      state_d [3];
  logic [NOTE_W-1:0] note_q  [3];
  logic [NOTE_W-1:0] note_d  [3];
  logic              pan_q   [3];
  logic              pan_d   [3];
  logic [DUR_W-1:0]  rem_q   [3];
  logic [DUR_W-1:0]  rem_d   [3];
  logic [2:0]        start_q;
  logic [2:0]        start_d;
  logic              steal_q;
  logic              steal_d;
  logic              ready_q;
  logic              ready_d;

  logic              accept;
  logic              load;
  logic              retrig_hit;
  logic [1:0]        retrig_idx;
  logic              free_hit;
  logic [1:0]        free_idx;
  logic [1:0]        steal_idx;
  logic [DUR_W-1:0]  best_rem;
  logic [1:0]        chosen_idx;

  assign note_if.note_ready_out = ready_q && !all_off_in;

  // Allocation looks at pre-tick state, so a voice expiring on this edge still counts as active.
  always_comb begin
    accept     = note_if.note_valid_in && note_if.note_ready_out;
    load       = accept && (note_if.note_dur_in != '0);
    retrig_hit = 1'b0;
    retrig_idx = 2'd0;
    free_hit   = 1'b0;
    free_idx   = 2'd0;
    for (int v = 2; v >= 0; v--) begin
      if (state_q[v] == PLAYING && note_q[v] == note_if.note_id_in) begin
        retrig_hit = 1'b1;
        retrig_idx = 2'(v);
      end
      if (state_q[v] == IDLE) begin
        free_hit = 1'b1;
        free_idx = 2'(v);
      end
    end
    steal_idx = 2'd0;
    best_rem  = rem_q[0];
    for (int v = 1; v < 3; v++) begin
      if (rem_q[v] < best_rem) begin
        best_rem  = rem_q[v];
        steal_idx = 2'(v);
      end
    end
    if (retrig_hit)    chosen_idx = retrig_idx;
    else if (free_hit) chosen_idx = free_idx;
    else               chosen_idx = steal_idx;
  end

  always_comb begin
    ready_d = 1'b1;
    steal_d = load && !retrig_hit && !free_hit;
    start_d = 3'b000;
    for (int v = 0; v < 3; v++) begin
      state_d[v] = state_q[v];
      note_d[v]  = note_q[v];
      pan_d[v]   = pan_q[v];
      rem_d[v]   = rem_q[v];
      if (all_off_in) begin
        state_d[v] = IDLE;
        rem_d[v]   = '0;
      end else if (load && chosen_idx == 2'(v)) begin
        state_d[v] = PLAYING;
        note_d[v]  = note_if.note_id_in;
        pan_d[v]   = note_if.note_pan_in;
        rem_d[v]   = note_if.note_dur_in;
        start_d[v] = 1'b1;
      end else if (sample_tick_in && state_q[v] == PLAYING) begin
        rem_d[v] = rem_q[v] - 1'b1;
        if (rem_q[v] == DUR_W'(1)) begin
          state_d[v] = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in_n) begin
      ready_q <= 1'b0;
      steal_q <= 1'b0;
      start_q <= 3'b000;
      for (int v = 0; v < 3; v++) begin
        state_q[v] <= IDLE;
        note_q[v]  <= '0;
        pan_q[v]   <= 1'b0;
        rem_q[v]   <= '0;
      end
    end else begin
      ready_q <= ready_d;
      steal_q <= steal_d;
      start_q <= start_d;
      for (int v = 0; v < 3; v++) begin
        state_q[v] <= state_d[v];
        note_q[v]  <= note_d[v];
        pan_q[v]   <= pan_d[v];
        rem_q[v]   <= rem_d[v];
      end
    end
  end

  generate
    for (genvar g = 0; g < 3; g++) begin : g_voice_out
      assign voice_active_out[g]                 = (state_q[g] == PLAYING);
      assign voice_note_out[g*NOTE_W +: NOTE_W] = note_q[g];
      assign voice_pan_out[g]                    = pan_q[g];
    end
  endgenerate

  assign voice_start_out = start_q;
  assign steal_out       = steal_q;

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_voice_allocator
// Brief    : Directed self-checking bench for voice_allocator.
// Revision : 1.0
// ============================================================================
module tb_voice_allocator;
  localparam int NOTE_W = 6;
  localparam int DUR_W  = 20;

  logic                clk_in = 1'b0;
  logic                rst_in_n;
  logic                sample_tick_in;
  logic                all_off_in;
  logic [2:0]          voice_active_out;
  logic [3*NOTE_W-1:0] voice_note_out;
  logic [2:0]          voice_pan_out;
  logic [2:0]          voice_start_out;
  logic                steal_out;

  int tests_run    = 0;
  int tests_failed = 0;

  voice_allocator_if #(.NOTE_W(NOTE_W), .DUR_W(DUR_W)) nif ();

  voice_allocator #(.NOTE_W(NOTE_W), .DUR_W(DUR_W)) dut (
    .clk_in           (clk_in),
    .rst_in_n         (rst_in_n),
    .sample_tick_in   (sample_tick_in),
    .all_off_in       (all_off_in),
    .note_if          (nif.slave),
    .voice_active_out (voice_active_out),
    .voice_note_out   (voice_note_out),
    .voice_pan_out    (voice_pan_out),
    .voice_start_out  (voice_start_out),
    .steal_out        (steal_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send(input logic [NOTE_W-1:0] id, input logic pan, input logic [DUR_W-1:0] dur);
    nif.note_valid_in = 1'b1;
    nif.note_id_in    = id;
    nif.note_pan_in   = pan;
    nif.note_dur_in   = dur;
    cyc();
    nif.note_valid_in = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      sample_tick_in = 1'b1;
      cyc();
      sample_tick_in = 1'b0;
    end
  endtask

  task automatic clear_all();
    all_off_in = 1'b1;
    cyc();
    all_off_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in_n = 1'b0;
    nif.note_valid_in = 1'b1;
    nif.note_id_in = 6'd5; nif.note_pan_in = 1'b1; nif.note_dur_in = 20'd4;
    cyc(); cyc(); cyc();
    tests_run++;
    if ({voice_active_out, voice_note_out, voice_pan_out, voice_start_out, steal_out, nif.note_ready_out} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: active=%b note=%h pan=%b start=%b steal=%b ready=%b, required all 0",
               voice_active_out, voice_note_out, voice_pan_out, voice_start_out, steal_out, nif.note_ready_out);
    end
    rst_in_n = 1'b1;
    nif.note_valid_in = 1'b0;
    cyc();
    tests_run++;
    if (nif.note_ready_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready_after_release: got %b required 1", nif.note_ready_out);
    end
    tests_run++;
    if (voice_active_out !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_no_accept: active=%b required 000", voice_active_out);
    end
  endtask

  task automatic test_fill();
    send(6'd5, 1'b1, 20'd4);
    tests_run++;
    if (voice_active_out !== 3'b001 || voice_start_out !== 3'b001) begin
      tests_failed++;
      $display("FAIL fill_a: active=%b start=%b required 001/001", voice_active_out, voice_start_out);
    end
    send(6'd7, 1'b0, 20'd4);
    tests_run++;
    if (voice_active_out !== 3'b011 || voice_start_out !== 3'b010) begin
      tests_failed++;
      $display("FAIL fill_b: active=%b start=%b required 011/010", voice_active_out, voice_start_out);
    end
    send(6'd9, 1'b1, 20'd4);
    tests_run++;
    if (voice_active_out !== 3'b111 || voice_start_out !== 3'b100 || steal_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill_c: active=%b start=%b steal=%b required 111/100/0", voice_active_out, voice_start_out, steal_out);
    end
    tests_run++;
    if (voice_note_out !== {6'd9, 6'd7, 6'd5} || voice_pan_out !== 3'b101) begin
      tests_failed++;
      $display("FAIL fill_note_pan: note=%h pan=%b required %h/101", voice_note_out, voice_pan_out, {6'd9, 6'd7, 6'd5});
    end
    cyc();
    tests_run++;
    if (voice_start_out !== 3'b000) begin
      tests_failed++;
      $display("FAIL fill_start_pulse: start=%b required 000", voice_start_out);
    end
    ticks(3);
    tests_run++;
    if (voice_active_out !== 3'b111) begin
      tests_failed++;
      $display("FAIL fill_3_ticks: active=%b required 111", voice_active_out);
    end
    ticks(1);
    tests_run++;
    if (voice_active_out !== 3'b000) begin
      tests_failed++;
      $display("FAIL fill_4_ticks: active=%b required 000", voice_active_out);
    end
  endtask

  task automatic test_retrigger();
    send(6'd5, 1'b1, 20'd4);
    ticks(2);
    send(6'd5, 1'b0, 20'd10);
    tests_run++;
    if (voice_start_out !== 3'b001 || voice_active_out !== 3'b001 || steal_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL retrig_choice: start=%b active=%b steal=%b required 001/001/0", voice_start_out, voice_active_out, steal_out);
    end
    tests_run++;
    if (voice_pan_out[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL retrig_pan: pan_a=%b required 0", voice_pan_out[0]);
    end
    ticks(9);
    tests_run++;
    if (voice_active_out !== 3'b001) begin
      tests_failed++;
      $display("FAIL retrig_reload_9: active=%b required 001", voice_active_out);
    end
    ticks(1);
    tests_run++;
    if (voice_active_out !== 3'b000) begin
      tests_failed++;
      $display("FAIL retrig_reload_10: active=%b required 000", voice_active_out);
    end
  endtask

  task automatic test_steal();
    send(6'd1, 1'b0, 20'd8);
    send(6'd2, 1'b0, 20'd3);
    send(6'd3, 1'b0, 20'd3);
    send(6'd12, 1'b1, 20'd5);
    tests_run++;
    if (steal_out !== 1'b1 || voice_start_out !== 3'b010) begin
      tests_failed++;
      $display("FAIL steal_choice: steal=%b start=%b required 1/010", steal_out, voice_start_out);
    end
    tests_run++;
    if (voice_note_out[NOTE_W +: NOTE_W] !== 6'd12 || voice_active_out !== 3'b111) begin
      tests_failed++;
      $display("FAIL steal_note_b: note_b=%0d active=%b required 12/111", voice_note_out[NOTE_W +: NOTE_W], voice_active_out);
    end
    cyc();
    tests_run++;
    if (steal_out !== 1'b0 || voice_start_out !== 3'b000) begin
      tests_failed++;
      $display("FAIL steal_pulse_width: steal=%b start=%b required 0/000", steal_out, voice_start_out);
    end
    // C (rem 3) expires first, proving B was the one reloaded to 5.
    ticks(3);
    tests_run++;
    if (voice_active_out !== 3'b011) begin
      tests_failed++;
      $display("FAIL steal_remaining: active=%b required 011", voice_active_out);
    end
    clear_all();
  endtask

  task automatic test_collision();
    send(6'd5, 1'b0, 20'd1);
    send(6'd6, 1'b0, 20'd3);
    send(6'd7, 1'b0, 20'd3);
    sample_tick_in = 1'b1;
    send(6'd5, 1'b1, 20'd4);
    sample_tick_in = 1'b0;
    tests_run++;
    if (voice_active_out !== 3'b111 || voice_start_out !== 3'b001 || steal_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL collision_a: active=%b start=%b steal=%b required 111/001/0", voice_active_out, voice_start_out, steal_out);
    end
    ticks(2);
    tests_run++;
    if (voice_active_out !== 3'b001) begin
      tests_failed++;
      $display("FAIL collision_bc_tick: active=%b required 001", voice_active_out);
    end
    ticks(2);
    tests_run++;
    if (voice_active_out !== 3'b000) begin
      tests_failed++;
      $display("FAIL collision_a_reload: active=%b required 000", voice_active_out);
    end
  endtask

  task automatic test_all_off();
    send(6'd21, 1'b1, 20'd50);
    send(6'd22, 1'b0, 20'd50);
    all_off_in = 1'b1;
    nif.note_valid_in = 1'b1;
    nif.note_id_in = 6'd30; nif.note_pan_in = 1'b0; nif.note_dur_in = 20'd5;
    #1;
    tests_run++;
    if (nif.note_ready_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL alloff_ready_c1: ready=%b required 0", nif.note_ready_out);
    end
    cyc();
    tests_run++;
    if (nif.note_ready_out !== 1'b0 || voice_active_out !== 3'b000) begin
      tests_failed++;
      $display("FAIL alloff_c2: ready=%b active=%b required 0/000", nif.note_ready_out, voice_active_out);
    end
    cyc();
    all_off_in = 1'b0;
    nif.note_valid_in = 1'b0;
    tests_run++;
    if (voice_active_out !== 3'b000 || voice_start_out !== 3'b000) begin
      tests_failed++;
      $display("FAIL alloff_nothing_accepted: active=%b start=%b required 000/000", voice_active_out, voice_start_out);
    end
    tests_run++;
    if (voice_note_out[NOTE_W-1:0] !== 6'd21 || voice_pan_out[1:0] !== 2'b01) begin
      tests_failed++;
      $display("FAIL alloff_hold_note: note_a=%0d pan=%b required 21/x01", voice_note_out[NOTE_W-1:0], voice_pan_out);
    end
    #1;
    tests_run++;
    if (nif.note_ready_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL alloff_ready_back: ready=%b required 1", nif.note_ready_out);
    end
    send(6'd33, 1'b0, 20'd0);
    tests_run++;
    if (voice_active_out !== 3'b000 || voice_start_out !== 3'b000 || steal_out !== 1'b0 ||
        voice_note_out[NOTE_W-1:0] !== 6'd21) begin
      tests_failed++;
      $display("FAIL dur0_no_change: active=%b start=%b steal=%b note_a=%0d required 000/000/0/21",
               voice_active_out, voice_start_out, steal_out, voice_note_out[NOTE_W-1:0]);
    end
  endtask

  initial begin
    rst_in_n          = 1'b0;
    sample_tick_in    = 1'b0;
    all_off_in        = 1'b0;
    nif.note_valid_in = 1'b0;
    nif.note_id_in    = '0;
    nif.note_pan_in   = 1'b0;
    nif.note_dur_in   = '0;
    test_reset();
    test_fill();
    test_retrigger();
    test_steal();
    test_collision();
    test_all_off();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
`default_nettype wire
